// File: rtl/uart_tx_frame_serializer.sv
// UART transmit frame serializer.
// Latches one byte, its parity bit and the frame format when a request is
// accepted. It then shifts out start, data (LSB first), optional parity and
// one or two stop bits, advancing one bit per baud tick.
module uart_tx_frame_serializer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       send,
  input  logic [7:0] reg_data,
  input  logic       parity_bit,
  input  logic [1:0] parity_type,
  input  logic       data_length,
  input  logic       stop_bits,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t     r_state;
  logic [7:0] r_data;
  logic       r_parityBit;
  logic       r_parityEn;
  logic       r_len8;
  logic       r_twoStop;
  logic [2:0] r_bitCnt;
  logic       r_dataTx;
  logic       r_active;
  logic       r_done;

  logic       w_lastBit;
  logic [2:0] w_nextIdx;
  logic       w_parityEnIn;

  // Odd (01) and even (10) insert a parity bit; 00 and 11 both mean none.
  assign w_parityEnIn = parity_type[0] ^ parity_type[1];
  assign w_lastBit    = (r_bitCnt == (r_len8 ? 3'd7 : 3'd6));
  assign w_nextIdx    = r_bitCnt + 3'd1;

  assign data_tx     = r_dataTx;
  assign active_flag = r_active;
  assign done_flag   = r_done;

  // Frame sequencer: all state and the registered line/status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_data      <= 8'h00;
      r_parityBit <= 1'b0;
      r_parityEn  <= 1'b0;
      r_len8      <= 1'b0;
      r_twoStop   <= 1'b0;
      r_bitCnt    <= 3'd0;
      r_dataTx    <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (send) begin
            r_data      <= reg_data;
            r_parityBit <= parity_bit;
            r_parityEn  <= w_parityEnIn;
            r_len8      <= data_length;
            r_twoStop   <= stop_bits;
            r_bitCnt    <= 3'd0;
            r_active    <= 1'b1;
            r_state     <= ARMED;
          end
        end
        ARMED: begin
          if (baud_tick) begin
            r_dataTx <= 1'b0;
            r_state  <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            r_dataTx <= r_data[0];
            r_bitCnt <= 3'd0;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (w_lastBit) begin
              if (r_parityEn) begin
                r_dataTx <= r_parityBit;
                r_state  <= PARITY;
              end else begin
                r_dataTx <= 1'b1;
                r_state  <= STOP1;
              end
            end else begin
              r_bitCnt <= w_nextIdx;
              r_dataTx <= r_data[w_nextIdx];
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            r_dataTx <= 1'b1;
            r_state  <= STOP1;
          end
        end
        STOP1: begin
          if (baud_tick) begin
            r_dataTx <= 1'b1;
            if (r_twoStop) begin
              r_state <= STOP2;
            end else begin
              r_state  <= IDLE;
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_bitCnt <= 3'd0;
            end
          end
        end
        STOP2: begin
          if (baud_tick) begin
            r_dataTx <= 1'b1;
            r_state  <= IDLE;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_bitCnt <= 3'd0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_dataTx <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
